// File: rtl/mvu_stream_pkg.sv
// Shared definitions for the folded matrix-vector unit: fold state, default geometry, lane types.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mvau_defn;

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } fold_state_t;

    // Counter width helper: a 1-entry counter still needs one bit of storage.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_MATRIX_W = 4;
    localparam int DEF_MATRIX_H = 4;
    localparam int DEF_SIMD     = 2;
    localparam int DEF_PE       = 2;
    localparam int DEF_TI       = 8;
    localparam int DEF_TW       = 8;
    localparam int DEF_TO       = 16;

    // Fold counts and counter widths of the default geometry.
    localparam int SF   = DEF_MATRIX_W / DEF_SIMD;
    localparam int NF   = DEF_MATRIX_H / DEF_PE;
    localparam int SF_W = cnt_width(SF);
    localparam int NF_W = cnt_width(NF);

    typedef logic [DEF_TI-1:0] act_lane_t;
    typedef logic [DEF_TW-1:0] wgt_lane_t;
    typedef logic [DEF_TO-1:0] acc_t;

endpackage

// File: rtl/mvu_stream_if.sv
// Activation, weight and result streams of the matrix-vector unit.
// Latency: n/a (signal bundle).
// Backpressure: valid/ready on each of the three streams.
interface mvu_stream_if
    import mvau_defn::*;
#(
    parameter int SIMD = DEF_SIMD,
    parameter int PE   = DEF_PE,
    parameter int TI   = DEF_TI,
    parameter int TW   = DEF_TW,
    parameter int TO   = DEF_TO
) ();
    logic                   in_v;
    logic                   in_rdy;
    logic [SIMD*TI-1:0]     in_act;
    logic                   wgt_v;
    logic                   wgt_rdy;
    logic [PE*SIMD*TW-1:0]  in_wgt;
    logic                   out_v;
    logic                   out_rdy;
    logic [PE*TO-1:0]       out;

    modport master (
        output in_v, in_act, wgt_v, in_wgt, out_rdy,
        input  in_rdy, wgt_rdy, out_v, out
    );

    modport slave (
        input  in_v, in_act, wgt_v, in_wgt, out_rdy,
        output in_rdy, wgt_rdy, out_v, out
    );
endinterface

// File: rtl/mvu_stream_dot.sv
// SIMD-lane dot product of one PE row against the current activation beat.
// Latency: purely combinational.
// Backpressure: none (no state).
module mvu_stream_dot
    import mvau_defn::*;
#(
    parameter int SIMD   = DEF_SIMD,
    parameter int TI     = DEF_TI,
    parameter int TW     = DEF_TW,
    parameter int TO     = DEF_TO,
    parameter bit SIGNED = 1'b1
) (
    input  logic [SIMD*TI-1:0] act,
    input  logic [SIMD*TW-1:0] wgt,
    output logic [TO-1:0]      dot
);
    localparam int PW = TI + TW;

    logic [TI-1:0] a;
    logic [TW-1:0] w;
    logic [PW-1:0] a_x;
    logic [PW-1:0] w_x;
    logic [PW-1:0] prod;
    logic [TO-1:0] term;

    // Extend each lane to full product width, multiply, re-extend to the accumulator width and sum.
    always_comb begin
        a    = '0;
        w    = '0;
        a_x  = '0;
        w_x  = '0;
        prod = '0;
        term = '0;
        dot  = '0;
        for (int s = 0; s < SIMD; s++) begin
            a = act[s*TI +: TI];
            w = wgt[s*TW +: TW];
            if (SIGNED) begin
                a_x = PW'($signed(a));
                w_x = PW'($signed(w));
            end else begin
                a_x = PW'(a);
                w_x = PW'(w);
            end
            // Low PW bits of the extended product are exact for both signednesses.
            prod = a_x * w_x;
            if (SIGNED) begin
                term = TO'($signed(prod));
            end else begin
                term = TO'(prod);
            end
            dot = dot + term;
        end
    end
endmodule

// File: rtl/mvu_stream.sv
// Folded MatrixH x MatrixW matrix-vector unit: buffers one input vector and replays it for every PE row fold.
// Latency: one cycle from the last beat of a fold to out_v with the final sums.
// Backpressure: last beat of a fold stalls while an unaccepted result is held; earlier beats keep flowing.
module mvu_stream
    import mvau_defn::*;
#(
    parameter int MatrixW = DEF_MATRIX_W,
    parameter int MatrixH = DEF_MATRIX_H,
    parameter int SIMD    = DEF_SIMD,
    parameter int PE      = DEF_PE,
    parameter int TI      = DEF_TI,
    parameter int TW      = DEF_TW,
    parameter int TO      = DEF_TO,
    parameter bit SIGNED  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mvu_stream_if.slave  bus
);
    localparam int SF_LEN = MatrixW / SIMD;
    localparam int NF_LEN = MatrixH / PE;
    localparam int SF_CW  = cnt_width(SF_LEN);
    localparam int NF_CW  = cnt_width(NF_LEN);
    localparam logic [SF_CW-1:0] SF_LAST = SF_CW'(SF_LEN - 1);
    localparam logic [NF_CW-1:0] NF_LAST = NF_CW'(NF_LEN - 1);

    if ((MatrixW % SIMD) != 0) begin : g_bad_width
        $fatal(1, "mvu_stream: MatrixW must be a multiple of SIMD");
    end
    if ((MatrixH % PE) != 0) begin : g_bad_height
        $fatal(1, "mvu_stream: MatrixH must be a multiple of PE");
    end

    fold_state_t          state;
    logic [SF_CW-1:0]     sf;
    logic [NF_CW-1:0]     nf;
    logic [SIMD*TI-1:0]   act_buf [SF_LEN];
    logic [TO-1:0]        acc     [PE];
    logic [TO-1:0]        dot     [PE];
    logic [TO-1:0]        sum     [PE];
    logic [PE*TO-1:0]     out_q;
    logic                 out_v_q;

    logic                 act_avail;
    logic                 last_beat;
    logic                 block;
    logic                 fire;
    logic [SIMD*TI-1:0]   act_cur;

    // Beat qualification: the activation source depends on the fold, and only a last beat can be blocked by a held result.
    always_comb begin
        act_avail = (state == FILL) ? bus.in_v : 1'b1;
        last_beat = (sf == SF_LAST);
        block     = last_beat & out_v_q & ~bus.out_rdy;
        fire      = rst_n & bus.wgt_v & act_avail & ~block;
        act_cur   = (state == FILL) ? bus.in_act : act_buf[sf];
    end

    // Readies are held low during reset so nothing is taken from upstream mid-reset.
    assign bus.in_rdy  = rst_n & (state == FILL) & bus.wgt_v & ~block;
    assign bus.wgt_rdy = rst_n & act_avail & ~block;
    assign bus.out_v   = out_v_q;
    assign bus.out     = out_q;

    for (genvar p = 0; p < PE; p++) begin : g_pe
        mvu_stream_dot #(
            .SIMD   (SIMD),
            .TI     (TI),
            .TW     (TW),
            .TO     (TO),
            .SIGNED (SIGNED)
        ) u_dot (
            .act (act_cur),
            .wgt (bus.in_wgt[p*SIMD*TW +: SIMD*TW]),
            .dot (dot[p])
        );
    end

    // Running sum for this beat; the first beat of a fold starts from zero instead of the stale accumulator.
    always_comb begin
        for (int p = 0; p < PE; p++) begin
            if (sf == '0) begin
                sum[p] = dot[p];
            end else begin
                sum[p] = acc[p] + dot[p];
            end
        end
    end

    // Fold sequencing, accumulation and the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FILL;
            sf      <= '0;
            nf      <= '0;
            out_v_q <= 1'b0;
            out_q   <= '0;
            for (int p = 0; p < PE; p++) begin
                acc[p] <= '0;
            end
        end else begin
            if (out_v_q && bus.out_rdy) begin
                out_v_q <= 1'b0;
            end
            if (fire) begin
                for (int p = 0; p < PE; p++) begin
                    acc[p] <= sum[p];
                end
                if (last_beat) begin
                    // The last beat's dot goes straight into the result, so no extra drain cycle.
                    for (int p = 0; p < PE; p++) begin
                        out_q[p*TO +: TO] <= sum[p];
                    end
                    out_v_q <= 1'b1;
                    sf      <= '0;
                    if (nf == NF_LAST) begin
                        nf    <= '0;
                        state <= FILL;
                    end else begin
                        nf    <= nf + 1'b1;
                        state <= REPLAY;
                    end
                end else begin
                    sf <= sf + 1'b1;
                end
            end
        end
    end

    // Capture the vector during fold 0 so later folds can replay it without upstream involvement.
    always_ff @(posedge clk) begin
        if (fire && (state == FILL)) begin
            act_buf[sf] <= bus.in_act;
        end
    end
endmodule

// File: tb/tb_mvu_stream.sv
module tb_mvu_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mvu_stream_if #(.SIMD(2), .PE(2), .TI(8), .TW(8), .TO(16)) bus_a ();
    mvu_stream_if #(.SIMD(2), .PE(2), .TI(8), .TW(8), .TO(8))  bus_s ();
    mvu_stream_if #(.SIMD(2), .PE(2), .TI(8), .TW(8), .TO(8))  bus_u ();

    mvu_stream #(.MatrixW(4), .MatrixH(4), .SIMD(2), .PE(2), .TI(8), .TW(8), .TO(16), .SIGNED(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mvu_stream #(.MatrixW(4), .MatrixH(2), .SIMD(2), .PE(2), .TI(8), .TW(8), .TO(8), .SIGNED(1'b1))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    mvu_stream #(.MatrixW(4), .MatrixH(2), .SIMD(2), .PE(2), .TI(8), .TW(8), .TO(8), .SIGNED(1'b0))
        dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outv_cnt = 0;
    int viol = 0;
    int rdy_in_replay = 0;
    bit fill_phase = 1'b1;

    logic [7:0]  va [4];
    logic [7:0]  vw [4][4];
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the main unit away from the clock edge: collect accepted words and protocol violations.
    always @(negedge clk) begin
        if (bus_a.out_v) outv_cnt++;
        if (bus_a.out_v && bus_a.out_rdy) got_q.push_back(bus_a.out);
        if (bus_a.in_rdy && !bus_a.wgt_v) viol++;
        if (fill_phase && bus_a.wgt_v && bus_a.wgt_rdy && !bus_a.in_v) viol++;
        if (fill_phase && ((bus_a.in_v && bus_a.in_rdy) != (bus_a.wgt_v && bus_a.wgt_rdy))) viol++;
        if (!fill_phase && bus_a.in_rdy) rdy_in_replay++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input int fold);
        logic [31:0] w;
        int acc;
        w = '0;
        for (int p = 0; p < 2; p++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) begin
                acc += int'($signed(va[c])) * int'($signed(vw[fold*2+p][c]));
            end
            w[p*16 +: 16] = acc[15:0];
        end
        return w;
    endfunction

    task automatic drive_beat(input int k);
        int nf = k / 2;
        int sf = k % 2;
        fill_phase = (nf == 0);
        bus_a.in_act = {va[sf*2+1], va[sf*2]};
        bus_a.in_wgt = {vw[nf*2+1][sf*2+1], vw[nf*2+1][sf*2], vw[nf*2][sf*2+1], vw[nf*2][sf*2]};
        bus_a.wgt_v = 1'b1;
        bus_a.in_v = (nf == 0);
    endtask

    task automatic send_vec(input bit bubbles);
        for (int k = 0; k < 4; k++) begin
            bit done = 1'b0;
            int guard = 0;
            drive_beat(k);
            while (!done) begin
                if (bubbles) begin
                    bus_a.wgt_v = ($urandom_range(0, 3) != 0);
                    bus_a.in_v = (k < 2) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                    bus_a.out_rdy = ($urandom_range(0, 3) != 0);
                end
                @(negedge clk);
                done = bus_a.wgt_v && bus_a.wgt_rdy;
                @(posedge clk); #1;
                guard++;
                if (!done && guard > 200) begin
                    checks++; errors++;
                    $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles, required acceptance", k, guard);
                    done = 1'b1;
                end
            end
        end
        bus_a.wgt_v = 1'b0;
        bus_a.in_v = 1'b0;
        fill_phase = 1'b1;
    endtask

    task automatic wait_q(input int n);
        for (int g = 0; g < 100 && got_q.size() < n; g++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.wgt_v = 1'b1; bus_a.in_v = 1'b1; bus_a.out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_a.in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy: got %b want 0", bus_a.in_rdy); end
        checks++; if (bus_a.wgt_rdy !== 1'b0) begin errors++; $display("FAIL rst_wgt_rdy: got %b want 0", bus_a.wgt_rdy); end
        checks++; if (bus_a.out_v !== 1'b0) begin errors++; $display("FAIL rst_out_v: got %b want 0", bus_a.out_v); end
        checks++; if (bus_a.out !== 32'h0) begin errors++; $display("FAIL rst_out: got %h want 0", bus_a.out); end
        checks++; if (bus_s.out !== 16'h0) begin errors++; $display("FAIL rst_out_s: got %h want 0", bus_s.out); end
        @(posedge clk); #1;
        bus_a.wgt_v = 1'b0; bus_a.in_v = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.wgt_rdy !== 1'b0) begin errors++; $display("FAIL idle_wgt_rdy: got %b want 0", bus_a.wgt_rdy); end
        bus_a.wgt_v = 1'b1;
        #1;
        checks++; if (bus_a.in_rdy !== 1'b1) begin errors++; $display("FAIL fill_in_rdy: got %b want 1", bus_a.in_rdy); end
        checks++; if (bus_a.wgt_rdy !== 1'b0) begin errors++; $display("FAIL fill_no_act_wgt_rdy: got %b want 0", bus_a.wgt_rdy); end
        bus_a.wgt_v = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vw = '{'{8'd1, 8'd1, 8'd1, 8'd1},
               '{8'd1, 8'd0, 8'd0, 8'd0},
               '{8'd0, 8'd0, 8'd0, 8'd1},
               '{8'd2, 8'hFF, 8'd0, 8'd0}};
        bus_a.out_rdy = 1'b1;
        got_q.delete(); viol = 0; rdy_in_replay = 0;
        send_vec(1'b0);
        wait_q(2);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL basic_count: got %0d want 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0] !== 32'h0001_000A) begin errors++; $display("FAIL basic_word0: got %h want 0001000a", got_q[0]); end
            checks++; if (got_q[1] !== 32'h0000_0004) begin errors++; $display("FAIL basic_word1: got %h want 00000004", got_q[1]); end
        end
        checks++; if (rdy_in_replay != 0) begin errors++; $display("FAIL replay_in_rdy: got %0d high cycles want 0", rdy_in_replay); end
        checks++; if (viol != 0) begin errors++; $display("FAIL basic_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_wrap();
        logic [15:0] act_s [2] = '{16'h7F7F, 16'h0101};
        logic [31:0] wgt_s [2] = '{32'h7F7F_7F7F, 32'h0202_0202};
        logic [15:0] act_u [2] = '{16'hFFFF, 16'h0101};
        logic [31:0] wgt_u [2] = '{32'hFFFF_FFFF, 32'h0202_0202};
        logic [15:0] exp_w [2] = '{16'h0404, 16'h0808};
        bus_s.out_rdy = 1'b1; bus_u.out_rdy = 1'b1;
        for (int v = 0; v < 2; v++) begin
            for (int b = 0; b < 2; b++) begin
                bit done = 1'b0;
                bus_s.in_act = act_s[v]; bus_s.in_wgt = wgt_s[v]; bus_s.in_v = 1'b1; bus_s.wgt_v = 1'b1;
                bus_u.in_act = act_u[v]; bus_u.in_wgt = wgt_u[v]; bus_u.in_v = 1'b1; bus_u.wgt_v = 1'b1;
                for (int g = 0; g < 20 && !done; g++) begin
                    @(negedge clk);
                    done = bus_s.in_rdy && bus_s.wgt_rdy && bus_u.in_rdy && bus_u.wgt_rdy;
                    @(posedge clk); #1;
                end
                checks++; if (!done) begin errors++; $display("FAIL wrap_accept: vec %0d beat %0d got no accept want accept", v, b); end
            end
            bus_s.in_v = 1'b0; bus_s.wgt_v = 1'b0; bus_u.in_v = 1'b0; bus_u.wgt_v = 1'b0;
            @(negedge clk);
            checks++; if (bus_s.out_v !== 1'b1 || bus_s.out !== exp_w[v]) begin errors++; $display("FAIL wrap_signed: vec %0d got v=%b %h want v=1 %h", v, bus_s.out_v, bus_s.out, exp_w[v]); end
            checks++; if (bus_u.out_v !== 1'b1 || bus_u.out !== exp_w[v]) begin errors++; $display("FAIL wrap_unsigned: vec %0d got v=%b %h want v=1 %h", v, bus_u.out_v, bus_u.out, exp_w[v]); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (bus_s.out_v !== 1'b0) begin errors++; $display("FAIL wrap_drop: vec %0d got out_v=%b want 0", v, bus_s.out_v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vw = '{'{8'd1, 8'd1, 8'd1, 8'd1},
               '{8'd1, 8'd0, 8'd0, 8'd0},
               '{8'd0, 8'd0, 8'd0, 8'd1},
               '{8'd2, 8'hFF, 8'd0, 8'd0}};
        got_q.delete();
        bus_a.out_rdy = 1'b0;
        drive_beat(0); @(posedge clk); #1;
        drive_beat(1); @(posedge clk); #1;
        drive_beat(2);
        @(negedge clk);
        checks++; if (bus_a.out_v !== 1'b1 || bus_a.out !== 32'h0001_000A) begin errors++; $display("FAIL bp_first: got v=%b %h want v=1 0001000a", bus_a.out_v, bus_a.out); end
        checks++; if (bus_a.wgt_rdy !== 1'b1) begin errors++; $display("FAIL bp_sf0_fires: got wgt_rdy=%b want 1", bus_a.wgt_rdy); end
        @(posedge clk); #1;
        drive_beat(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus_a.wgt_rdy !== 1'b0) begin errors++; $display("FAIL bp_last_stalls: cycle %0d got wgt_rdy=%b want 0", i, bus_a.wgt_rdy); end
            checks++; if (bus_a.out_v !== 1'b1 || bus_a.out !== 32'h0001_000A) begin errors++; $display("FAIL bp_hold: cycle %0d got v=%b %h want v=1 0001000a", i, bus_a.out_v, bus_a.out); end
            @(posedge clk); #1;
        end
        bus_a.out_rdy = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.wgt_rdy !== 1'b1) begin errors++; $display("FAIL bp_release: got wgt_rdy=%b want 1", bus_a.wgt_rdy); end
        @(posedge clk); #1;
        bus_a.wgt_v = 1'b0; bus_a.in_v = 1'b0; fill_phase = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.out_v !== 1'b1 || bus_a.out !== 32'h0000_0004) begin errors++; $display("FAIL bp_second: got v=%b %h want v=1 00000004", bus_a.out_v, bus_a.out); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus_a.out_v !== 1'b0) begin errors++; $display("FAIL bp_drain: got out_v=%b want 0", bus_a.out_v); end
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL bp_count: got %0d words want 2", got_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles();
        got_q.delete(); exp_q.delete(); viol = 0; rdy_in_replay = 0;
        for (int v = 0; v < 50; v++) begin
            for (int c = 0; c < 4; c++) begin
                va[c] = 8'($urandom);
                for (int r = 0; r < 4; r++) vw[r][c] = 8'($urandom);
            end
            exp_q.push_back(model(0));
            exp_q.push_back(model(1));
            send_vec(1'b1);
        end
        bus_a.out_rdy = 1'b1;
        wait_q(100);
        checks++; if (got_q.size() != 100) begin errors++; $display("FAIL bubble_count: got %0d words want 100", got_q.size()); end
        for (int i = 0; i < 100 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bubble_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL bubble_protocol: got %0d violations want 0", viol); end
        checks++; if (rdy_in_replay != 0) begin errors++; $display("FAIL bubble_replay_rdy: got %0d want 0", rdy_in_replay); end
    endtask

    task automatic test_reset_mid();
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vw = '{'{8'd1, 8'd1, 8'd1, 8'd1},
               '{8'd1, 8'd0, 8'd0, 8'd0},
               '{8'd0, 8'd0, 8'd0, 8'd1},
               '{8'd2, 8'hFF, 8'd0, 8'd0}};
        bus_a.out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_beat(k);
            @(posedge clk); #1;
        end
        drive_beat(3);
        bus_a.in_v = 1'b1;
        fill_phase = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus_a.out_v !== 1'b0) begin errors++; $display("FAIL midrst_out_v: got %b want 0", bus_a.out_v); end
        checks++; if (bus_a.in_rdy !== 1'b0) begin errors++; $display("FAIL midrst_in_rdy: got %b want 0", bus_a.in_rdy); end
        @(posedge clk); #1;
        bus_a.wgt_v = 1'b0; bus_a.in_v = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        got_q.delete();
        va = '{8'hFD, 8'd5, 8'd7, 8'hFE};
        vw = '{'{8'd1, 8'd2, 8'd3, 8'd4},
               '{8'hFF, 8'hFF, 8'hFF, 8'hFF},
               '{8'd0, 8'd0, 8'd2, 8'd0},
               '{8'd10, 8'd0, 8'd0, 8'd10}};
        send_vec(1'b0);
        wait_q(2);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d want 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0] !== 32'hFFF9_0014) begin errors++; $display("FAIL midrst_word0: got %h want fff90014", got_q[0]); end
            checks++; if (got_q[1] !== 32'hFFCE_000E) begin errors++; $display("FAIL midrst_word1: got %h want ffce000e", got_q[1]); end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        got_q.delete(); exp_q.delete();
        bus_a.out_rdy = 1'b1;
        @(posedge clk); #1;
        outv_cnt = 0;
        c0 = cyc;
        for (int v = 0; v < 3; v++) begin
            for (int c = 0; c < 4; c++) begin
                va[c] = 8'($urandom);
                for (int r = 0; r < 4; r++) vw[r][c] = 8'($urandom);
            end
            exp_q.push_back(model(0));
            exp_q.push_back(model(1));
            send_vec(1'b0);
        end
        checks++; if (cyc - c0 != 12) begin errors++; $display("FAIL b2b_cycles: got %0d cycles want 12", cyc - c0); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (outv_cnt != 6) begin errors++; $display("FAIL b2b_outv_pulses: got %0d want 6", outv_cnt); end
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        bus_a.in_v = 1'b0; bus_a.wgt_v = 1'b0; bus_a.in_act = '0; bus_a.in_wgt = '0; bus_a.out_rdy = 1'b0;
        bus_s.in_v = 1'b0; bus_s.wgt_v = 1'b0; bus_s.in_act = '0; bus_s.in_wgt = '0; bus_s.out_rdy = 1'b0;
        bus_u.in_v = 1'b0; bus_u.wgt_v = 1'b0; bus_u.in_act = '0; bus_u.in_wgt = '0; bus_u.out_rdy = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mvu_stream.md
Name: mvu_stream

Overview:
Folded, stream-driven matrix-vector unit that generalises the single-pass SIMD×PE array to an arbitrary MatrixH×MatrixW weight matrix. Each input vector arrives as SF = MatrixW/SIMD activation beats. The vector is buffered locally and replayed for NF = MatrixH/PE row folds. Every fold produces one PE-wide output word, exchanged over valid/ready handshakes on input, weight and output streams. It sits between the input activation FIFO and the threshold/activation stage of the MVAU.

Parameters:
MatrixW, 4, matrix columns (input vector length); must be a multiple of SIMD
MatrixH, 4, matrix rows (output vector length); must be a multiple of PE
SIMD, 2, activation/weight lanes processed per beat
PE, 2, output rows computed in parallel
TI, 8, activation lane width in bits
TW, 8, weight lane width in bits
TO, 16, accumulator/output width per PE in bits
SIGNED, 1, 1 = activations and weights are two's complement; 0 = unsigned

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_v  in  1  activation beat valid
in_rdy  out  1  activation beat accepted when in_v & in_rdy
in_act  in  SIMD*TI  activation lanes; lane s at bits [s*TI +: TI]
wgt_v  in  1  weight beat valid
wgt_rdy  out  1  weight beat accepted when wgt_v & wgt_rdy
in_wgt  in  PE*SIMD*TW  weights; PE p, lane s at bits [(p*SIMD+s)*TW +: TW]
out_v  out  1  output word valid
out_rdy  in  1  downstream ready
out  out  PE*TO  results; PE p at bits [p*TO +: TO]

Behaviour:
- One clock, clk; reset is synchronous and active-low on rst_n.
- Reset values: in_rdy=0, wgt_rdy=0, out_v=0, out=0; all counters (sf, nf) = 0; accumulators = 0; state = FILL. Activation buffer contents are don't-care.
- Counters:
  - sf counts 0..SF-1 and wraps to 0.
  - nf counts 0..NF-1; it increments when sf wraps and wraps to 0, returning state to FILL.
- States:
  - FILL (nf=0): the beat's activation comes from in_act and is written to buf[sf].
  - REPLAY (nf>0): the activation comes from buf[sf]; in_rdy=0.
- Transitions: FILL→REPLAY on the last beat of fold 0 when NF>1; REPLAY→FILL on the last beat of fold NF-1; NF=1 stays in FILL.
- A beat fires when all of the following hold:
  - weight available (wgt_v);
  - activation available (FILL: in_v; REPLAY: always);
  - no blocking output: a last beat (sf=SF-1) may not fire while out_v & !out_rdy.
- Ready outputs: in_rdy = (state==FILL) & wgt_v & !block; wgt_rdy = act_avail & !block. Both are combinational.
- Arithmetic per PE p: dot = Σ_s act[s]·wgt[p][s].
  - Operands are sign-extended when SIGNED=1, zero-extended otherwise.
  - Products are TI+TW bits and are extended to TO.
  - acc_p ← (sf==0 ? 0 : acc_p) + dot, wrapping modulo 2^TO with no saturation.
- Row mapping: PE p in fold nf computes matrix row nf*PE+p.
- Latency: on the cycle after the last beat of a fold fires, out_v=1 and out holds the final sums. The last beat's dot is folded directly into the out register, so the total latency is 1 cycle.
- Output stall: out and out_v hold while out_v & !out_rdy. Beats with sf<SF-1 continue to fire during a stall.
- Simultaneous events: if out_rdy=1 and a last beat fires in the same cycle, out loads the new word and out_v stays 1 with no bubble. If out_rdy=1 and no last beat fires, out_v drops to 0.
- Reset asserted mid-fold or mid-replay discards partial sums and the buffered vector. The next accepted in_act beat is column 0 of a new vector.
- MatrixW%SIMD≠0 or MatrixH%PE≠0 must trigger a $fatal elaboration check.

Decomposition:
- Shared package (mvau_defn) holds:
  - derived constants SF and NF, plus the counter widths $clog2(SF) and $clog2(NF), floored at 1;
  - the state enum fold_state_t {FILL, REPLAY};
  - typedefs act_lane_t, wgt_lane_t and acc_t.
- One sub-module, mvu_stream_dot: a purely combinational SIMD-lane multiply/adder tree with signedness selection, instantiated PE times.
- Counters, buffer, FSM, accumulators and handshakes live in mvu_stream.

Test Plan:
- Config: SIMD=2, PE=2, MatrixW=4, MatrixH=4, TO=16, SIGNED=1. Activations [1,2,3,4]; rows r0=[1,1,1,1], r1=[1,0,0,0], r2=[0,0,0,1], r3=[2,-1,0,0] → out words {PE1=1,PE0=10}, then {PE1=0,PE0=4}. in_rdy must be low during the second fold.
- Signed wrap, TO=8: all lanes 127 for acts and weights, SF=2 → each PE outputs 4 (64516 mod 256). With SIGNED=0, acts 255 and weights 255 → 4×65025 mod 256 = 4.
- Backpressure: hold out_rdy=0 after the first word → out stays 10/1, fold-1 beat sf=0 fires, beat sf=1 stalls. Raise out_rdy → second word appears next cycle with no lost or duplicated words.
- Bubbles: randomly deassert in_v and wgt_v over 50 random vectors → outputs match the scoreboard. A beat never fires without both streams valid in FILL.
- Reset mid-replay: pulse rst_n=0 during fold 1 → next cycle out_v=0, in_rdy=0. A new vector then computes correctly from scratch.
- Back-to-back: out_rdy tied 1 with continuous vectors → out_v pulses exactly once per SF beats of sustained throughput, one output word per fold.
